mask_iter: RTL and testbench
============================

Name: mask_iter

Overview:
- Sequential companion to the combinational mask generator. It accepts a W-bit vector and walks it bit by bit.
- Emits the index of each set bit as a separate valid/ready beat, one per cycle, and flags the final beat.
- Used wherever a masked request vector (pending lanes, ready slots) must be serviced one element at a time.

Parameters:
- W, 8, width of input vector; legal range W >= 1.
- FROM_LSB, 1'b1, 1: emit lowest set index first; 0: emit highest set index first.
- IDX_W, (W > 1) ? $clog2(W) : 1, width of emitted index (derived; not overridden).

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- i_flush  input  1  synchronous abort of the current vector.
- i_vec_vld  input  1  input vector valid.
- i_vec  input  W  vector to iterate.
- o_vec_rdy  output  1  block can accept a vector this cycle.
- o_idx_vld  output  1  emitted index valid.
- o_idx  output  IDX_W  index of the current selected set bit.
- o_idx_last  output  1  current beat is the final set bit of the vector.
- i_idx_rdy  input  1  downstream accepts the index.
- o_busy  output  1  iteration in progress (state ITER).

Behaviour:
- One clock domain. Reset is synchronous and active-high; name `rst`, clock `clk`.
- State and storage:
  - States: IDLE, ITER.
  - Register `pend[W-1:0]` holds the bits not yet emitted.
- Reset (rst=1 at a clk edge): state=IDLE, pend=0.
  - While rst is high: o_vec_rdy=0, o_idx_vld=0, o_idx_last=0, o_busy=0, o_idx=0.
  - First cycle after rst deasserts: o_vec_rdy=1.
- Precedence: rst > i_flush > normal operation.
- IDLE:
  - o_vec_rdy=1 (0 if i_flush=1); o_idx_vld=0; o_busy=0.
  - Accept on i_vec_vld & o_vec_rdy.
  - Nonzero i_vec: pend<=i_vec; go to ITER.
  - i_vec==0: accepted and discarded; stay IDLE; no output beat.
- ITER:
  - o_idx_vld=1; o_busy=1.
  - sel = lowest set bit of pend (FROM_LSB=1) or highest set bit (FROM_LSB=0).
  - o_idx = binary index of sel; o_idx_last = (pend has exactly one bit set).
  - o_idx and o_idx_last are combinational from pend only. They are stable while o_idx_vld=1 and i_idx_rdy=0.
  - On handshake (o_idx_vld & i_idx_rdy): pend <= pend & ~sel.
  - Handshake on a non-last beat: stay ITER.
  - Handshake on the last beat: go to IDLE.
- Back-to-back vectors:
  - In ITER, o_vec_rdy = o_idx_last & i_idx_rdy & ~i_flush.
  - A vector accepted on the last-beat handshake loads pend directly.
  - Nonzero vector: stay ITER. Zero vector: go to IDLE.
  - No bubble between vectors.
- Latency:
  - Vector accept at edge N gives the first o_idx_vld in cycle N+1.
  - Each further beat takes 1 cycle under continuous i_idx_rdy=1.
  - A vector with k set bits occupies exactly k output cycles with no backpressure.
- Flush (i_flush=1, rst=0):
  - Next state IDLE, pend<=0.
  - A handshake completing in that same cycle still counts as delivered; downstream sees it.
  - o_vec_rdy=0 during the flush cycle, so no vector is accepted then.
- Backpressure: i_idx_rdy=0 holds pend and all outputs unchanged indefinitely.
- W=1: o_idx is always 0; every beat has o_idx_last=1.
- Widths: o_idx is zero-extended to IDX_W. Index arithmetic is unsigned; no wrap is possible.
- Interface contract: i_vec is sampled only on accept; the input side need not hold it afterwards.
- Assertions:
  - o_idx_vld implies pend != 0.
  - o_idx < W.
  - o_idx and o_idx_last are stable under stall.
  - No o_idx_vld in IDLE.

Test Plan:
- Reset/idle: hold rst 3 cycles with i_vec_vld=1, i_vec=8'hFF.
  - During reset: o_vec_rdy=0, o_idx_vld=0, and pend is not loaded.
  - After reset: o_vec_rdy=1 on the first cycle.
- Basic LSB order: W=8, FROM_LSB=1, i_vec=8'b1001_0110, i_idx_rdy=1.
  - Indices 1,2,4,7 on consecutive cycles; o_idx_last=1 only on 7; then IDLE.
- MSB order with stall: FROM_LSB=0, i_vec=8'b0010_0001, i_idx_rdy toggling 0,0,1,0,1.
  - o_idx=5 held for 3 cycles, then 0 (last=1) held for 2 cycles.
  - Exactly 2 handshakes occur.
- Back-to-back: vec A=8'h81, then vec B=8'h02 presented throughout.
  - B is accepted on A's last-beat cycle.
  - Output stream is 0,7(last),1(last) with no gap cycle.
- Zero vector and flush:
  - i_vec=8'h00 is accepted with no output beat and the block stays IDLE.
  - Then i_vec=8'hF0 with i_flush pulsed after the index-4 handshake: indices 4 only, then IDLE.
  - o_vec_rdy=0 in the flush cycle.
- W=1 edge: i_vec=1'b1 repeatedly presented with i_idx_rdy=1.
  - Every cycle after the first shows o_idx_vld=1, o_idx=0, o_idx_last=1, with continuous back-to-back acceptance.

Source files
------------

// File: rtl/mask_iter.sv
// Purpose : walks a W-bit vector and emits the index of each set bit as one valid/ready beat.
// Latency : first index the cycle after the vector is accepted, then one index per cycle.
// Backpr. : i_idx_rdy=0 freezes pend and every output; a new vector is taken only on the last beat.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   i_flush           abort the current vector (pend cleared, back to IDLE)
//   i_vec_vld/i_vec   vector input, handshaked with o_vec_rdy
//   o_idx_vld/o_idx   index of the selected set bit, handshaked with i_idx_rdy
//   o_idx_last        the selected bit is the only one left in pend
//   o_busy            iteration in progress
module mask_iter #(
    parameter int W        = 8,
    parameter bit FROM_LSB = 1'b1,
    localparam int IDX_W   = (W > 1) ? $clog2(W) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_vec_vld,
    input  logic [W-1:0]     i_vec,
    output logic             o_vec_rdy,
    output logic             o_idx_vld,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_idx_last,
    input  logic             i_idx_rdy,
    output logic             o_busy
);

    typedef enum logic {
        IDLE = 1'b0,
        ITER = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [W-1:0]     pend;
    logic [W-1:0]     pend_nxt;
    logic [W-1:0]     sel;
    logic [IDX_W-1:0] idx;
    logic             found;
    logic             last;
    logic             hs;
    logic             accept;

    // Priority pick over pend; the scan direction is fixed at elaboration.
    always_comb begin
        sel   = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (!found && pend[FROM_LSB ? i : (W - 1 - i)]) begin
                found                          = 1'b1;
                sel[FROM_LSB ? i : (W - 1 - i)] = 1'b1;
                idx                            = IDX_W'(FROM_LSB ? i : (W - 1 - i));
            end
        end
    end

    // Exactly one bit left: clearing the lowest set bit leaves nothing.
    assign last = (pend != '0) && ((pend & (pend - W'(1))) == '0);

    assign o_busy     = (state == ITER) && !rst;
    assign o_idx_vld  = (state == ITER) && !rst;
    assign o_idx      = rst ? '0 : idx;
    assign o_idx_last = last && !rst;
    assign hs         = o_idx_vld && i_idx_rdy;

    // In ITER a new vector may only slide in behind the final beat,
    // which is what makes back-to-back vectors bubble-free.
    always_comb begin
        o_vec_rdy = 1'b0;
        if (!rst && !i_flush) begin
            if (state == IDLE) o_vec_rdy = 1'b1;
            else               o_vec_rdy = last && i_idx_rdy;
        end
    end

    assign accept = i_vec_vld && o_vec_rdy;

    always_comb begin
        state_nxt = state;
        pend_nxt  = pend;
        if (i_flush) begin
            state_nxt = IDLE;
            pend_nxt  = '0;
        end else begin
            case (state)
                IDLE: begin
                    // A zero vector is accepted and dropped without leaving IDLE.
                    if (accept && (i_vec != '0)) begin
                        pend_nxt  = i_vec;
                        state_nxt = ITER;
                    end
                end
                ITER: begin
                    if (hs) begin
                        pend_nxt = pend & ~sel;
                        if (last) begin
                            state_nxt = IDLE;
                            if (accept) begin
                                pend_nxt = i_vec;
                                if (i_vec != '0) state_nxt = ITER;
                            end
                        end
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    pend_nxt  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pend  <= '0;
        end else begin
            state <= state_nxt;
            pend  <= pend_nxt;
        end
    end

    a_vld_has_pend: assert property (@(posedge clk) disable iff (rst)
        o_idx_vld |-> (pend != '0));
    a_idx_range: assert property (@(posedge clk) disable iff (rst)
        o_idx_vld |-> (32'(o_idx) < W));
    a_stall_stable: assert property (@(posedge clk) disable iff (rst)
        (o_idx_vld && !i_idx_rdy && !i_flush) |=>
        (o_idx_vld && $stable(o_idx) && $stable(o_idx_last)));
    a_idle_quiet: assert property (@(posedge clk) disable iff (rst)
        (state == IDLE) |-> !o_idx_vld);

endmodule

// File: tb/tb_mask_iter.sv
module tb_mask_iter;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       vec_vld;
    logic [7:0] vec;
    logic       idx_rdy;

    logic       l_vec_rdy, l_idx_vld, l_idx_last, l_busy;
    logic [2:0] l_idx;
    logic       m_vec_rdy, m_idx_vld, m_idx_last, m_busy;
    logic [2:0] m_idx;
    logic       s_vec_rdy, s_idx_vld, s_idx_last, s_busy;
    logic [0:0] s_idx;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mask_iter #(.W(8), .FROM_LSB(1'b1)) u_lsb (
        .clk(clk), .rst(rst), .i_flush(flush), .i_vec_vld(vec_vld), .i_vec(vec),
        .o_vec_rdy(l_vec_rdy), .o_idx_vld(l_idx_vld), .o_idx(l_idx),
        .o_idx_last(l_idx_last), .i_idx_rdy(idx_rdy), .o_busy(l_busy)
    );

    mask_iter #(.W(8), .FROM_LSB(1'b0)) u_msb (
        .clk(clk), .rst(rst), .i_flush(flush), .i_vec_vld(vec_vld), .i_vec(vec),
        .o_vec_rdy(m_vec_rdy), .o_idx_vld(m_idx_vld), .o_idx(m_idx),
        .o_idx_last(m_idx_last), .i_idx_rdy(idx_rdy), .o_busy(m_busy)
    );

    mask_iter #(.W(1), .FROM_LSB(1'b1)) u_one (
        .clk(clk), .rst(rst), .i_flush(flush), .i_vec_vld(vec_vld), .i_vec(vec[0:0]),
        .o_vec_rdy(s_vec_rdy), .o_idx_vld(s_idx_vld), .o_idx(s_idx),
        .o_idx_last(s_idx_last), .i_idx_rdy(idx_rdy), .o_busy(s_busy)
    );

    // Advance to just after the next rising edge, where inputs are driven.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; vec_vld = 1'b1; vec = 8'hFF; idx_rdy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            tests++;
            if ({l_vec_rdy, l_idx_vld, l_idx_last, l_busy, l_idx} !== 7'b0) begin
                fails++;
                $display("FAIL reset_outputs_lsb cyc%0d: got %b expected 0000000", k,
                         {l_vec_rdy, l_idx_vld, l_idx_last, l_busy, l_idx});
            end
            tests++;
            if ({m_vec_rdy, m_idx_vld, s_vec_rdy, s_idx_vld} !== 4'b0) begin
                fails++;
                $display("FAIL reset_outputs_msb_w1 cyc%0d: got %b expected 0000", k,
                         {m_vec_rdy, m_idx_vld, s_vec_rdy, s_idx_vld});
            end
            tick();
        end
        rst = 1'b0; vec_vld = 1'b0;
        @(negedge clk);
        tests++;
        if ({l_vec_rdy, l_idx_vld, m_vec_rdy, m_idx_vld} !== 4'b1010) begin
            fails++;
            $display("FAIL post_reset_rdy: got %b expected 1010",
                     {l_vec_rdy, l_idx_vld, m_vec_rdy, m_idx_vld});
        end
        tick();
        @(negedge clk);
        tests++;
        if ({l_idx_vld, l_busy, m_idx_vld, s_idx_vld} !== 4'b0) begin
            fails++;
            $display("FAIL reset_no_load: got %b expected 0000",
                     {l_idx_vld, l_busy, m_idx_vld, s_idx_vld});
        end
    endtask

    task automatic test_lsb_basic();
        int lsb_exp[4] = '{1, 2, 4, 7};
        int msb_exp[4] = '{7, 4, 2, 1};
        tick();
        vec = 8'b1001_0110; vec_vld = 1'b1; idx_rdy = 1'b1;
        @(negedge clk);
        tests++;
        if ({l_vec_rdy, l_idx_vld} !== 2'b10) begin
            fails++;
            $display("FAIL basic_accept: got %b expected 10", {l_vec_rdy, l_idx_vld});
        end
        tick();
        vec_vld = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            tests++;
            if ({l_idx_vld, l_idx, l_idx_last} !== {1'b1, 3'(lsb_exp[k]), (k == 3)}) begin
                fails++;
                $display("FAIL basic_lsb beat%0d: got vld/idx/last %b/%0d/%b expected 1/%0d/%b",
                         k, l_idx_vld, l_idx, l_idx_last, lsb_exp[k], (k == 3));
            end
            tests++;
            if ({m_idx_vld, m_idx, m_idx_last} !== {1'b1, 3'(msb_exp[k]), (k == 3)}) begin
                fails++;
                $display("FAIL basic_msb beat%0d: got vld/idx/last %b/%0d/%b expected 1/%0d/%b",
                         k, m_idx_vld, m_idx, m_idx_last, msb_exp[k], (k == 3));
            end
            tick();
        end
        @(negedge clk);
        tests++;
        if ({l_idx_vld, l_busy, l_vec_rdy, m_idx_vld, m_busy, m_vec_rdy} !== 6'b001001) begin
            fails++;
            $display("FAIL basic_back_idle: got %b expected 001001",
                     {l_idx_vld, l_busy, l_vec_rdy, m_idx_vld, m_busy, m_vec_rdy});
        end
    endtask

    task automatic test_msb_stall();
        bit pat[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        int hs = 0;
        tick();
        vec = 8'b0010_0001; vec_vld = 1'b1; idx_rdy = 1'b0;
        @(negedge clk);
        tests++;
        if (m_vec_rdy !== 1'b1) begin
            fails++;
            $display("FAIL stall_accept: got %b expected 1", m_vec_rdy);
        end
        tick();
        vec_vld = 1'b0;
        for (int k = 0; k < 5; k++) begin
            idx_rdy = pat[k];
            @(negedge clk);
            tests++;
            if ({m_idx_vld, m_idx, m_idx_last} !== {1'b1, (k < 3) ? 3'd5 : 3'd0, (k >= 3)}) begin
                fails++;
                $display("FAIL stall_msb cyc%0d: got vld/idx/last %b/%0d/%b expected 1/%0d/%b",
                         k, m_idx_vld, m_idx, m_idx_last, (k < 3) ? 5 : 0, (k >= 3));
            end
            if (m_idx_vld && idx_rdy) hs++;
            tick();
        end
        idx_rdy = 1'b1;
        tests++;
        if (hs !== 2) begin
            fails++;
            $display("FAIL stall_handshakes: got %0d expected 2", hs);
        end
        @(negedge clk);
        tests++;
        if ({m_idx_vld, m_busy} !== 2'b00) begin
            fails++;
            $display("FAIL stall_back_idle: got %b expected 00", {m_idx_vld, m_busy});
        end
    endtask

    task automatic test_back_to_back();
        int l_exp[3] = '{0, 7, 1};
        int m_exp[3] = '{7, 0, 1};
        bit last_exp[3] = '{1'b0, 1'b1, 1'b1};
        bit rdy_exp[3]  = '{1'b0, 1'b1, 1'b1};
        tick();
        vec = 8'h81; vec_vld = 1'b1; idx_rdy = 1'b1;
        tick();
        vec = 8'h02;
        for (int k = 0; k < 3; k++) begin
            if (k == 2) vec_vld = 1'b0;
            @(negedge clk);
            tests++;
            if ({l_idx_vld, l_idx, l_idx_last, l_vec_rdy} !==
                {1'b1, 3'(l_exp[k]), last_exp[k], rdy_exp[k]}) begin
                fails++;
                $display("FAIL b2b_lsb beat%0d: got vld/idx/last/rdy %b/%0d/%b/%b expected 1/%0d/%b/%b",
                         k, l_idx_vld, l_idx, l_idx_last, l_vec_rdy, l_exp[k], last_exp[k], rdy_exp[k]);
            end
            tests++;
            if ({m_idx_vld, m_idx, m_idx_last} !== {1'b1, 3'(m_exp[k]), last_exp[k]}) begin
                fails++;
                $display("FAIL b2b_msb beat%0d: got vld/idx/last %b/%0d/%b expected 1/%0d/%b",
                         k, m_idx_vld, m_idx, m_idx_last, m_exp[k], last_exp[k]);
            end
            tick();
        end
        @(negedge clk);
        tests++;
        if ({l_idx_vld, m_idx_vld} !== 2'b00) begin
            fails++;
            $display("FAIL b2b_back_idle: got %b expected 00", {l_idx_vld, m_idx_vld});
        end
    endtask

    task automatic test_zero_flush();
        tick();
        vec = 8'h00; vec_vld = 1'b1; idx_rdy = 1'b1;
        @(negedge clk);
        tests++;
        if (l_vec_rdy !== 1'b1) begin
            fails++;
            $display("FAIL zero_accept: got %b expected 1", l_vec_rdy);
        end
        tick();
        vec_vld = 1'b0;
        @(negedge clk);
        tests++;
        if ({l_idx_vld, l_busy, l_vec_rdy} !== 3'b001) begin
            fails++;
            $display("FAIL zero_no_beat: got %b expected 001", {l_idx_vld, l_busy, l_vec_rdy});
        end
        tick();
        vec = 8'hF0; vec_vld = 1'b1;
        tick();
        vec_vld = 1'b0;
        @(negedge clk);
        tests++;
        if ({l_idx_vld, l_idx, l_idx_last} !== {1'b1, 3'd4, 1'b0}) begin
            fails++;
            $display("FAIL flush_first_beat: got vld/idx/last %b/%0d/%b expected 1/4/0",
                     l_idx_vld, l_idx, l_idx_last);
        end
        tick();
        flush = 1'b1; idx_rdy = 1'b0; vec = 8'hFF; vec_vld = 1'b1;
        @(negedge clk);
        tests++;
        if ({l_vec_rdy, m_vec_rdy, s_vec_rdy} !== 3'b000) begin
            fails++;
            $display("FAIL flush_rdy_low: got %b expected 000", {l_vec_rdy, m_vec_rdy, s_vec_rdy});
        end
        tick();
        flush = 1'b0; vec_vld = 1'b0; idx_rdy = 1'b1;
        @(negedge clk);
        tests++;
        if ({l_idx_vld, l_busy, l_vec_rdy, m_idx_vld} !== 4'b0010) begin
            fails++;
            $display("FAIL flush_to_idle: got %b expected 0010",
                     {l_idx_vld, l_busy, l_vec_rdy, m_idx_vld});
        end
    endtask

    task automatic test_w1();
        tick();
        flush = 1'b1; vec_vld = 1'b0;
        tick();
        flush = 1'b0; vec = 8'h01; vec_vld = 1'b1; idx_rdy = 1'b1;
        @(negedge clk);
        tests++;
        if ({s_vec_rdy, s_idx_vld} !== 2'b10) begin
            fails++;
            $display("FAIL w1_first: got %b expected 10", {s_vec_rdy, s_idx_vld});
        end
        tick();
        for (int k = 1; k < 6; k++) begin
            @(negedge clk);
            tests++;
            if ({s_vec_rdy, s_idx_vld, s_idx, s_idx_last} !== 4'b1101) begin
                fails++;
                $display("FAIL w1_stream cyc%0d: got rdy/vld/idx/last %b expected 1101",
                         k, {s_vec_rdy, s_idx_vld, s_idx, s_idx_last});
            end
            tick();
        end
        vec_vld = 1'b0;
        tick();
        @(negedge clk);
        tests++;
        if ({s_idx_vld, s_busy} !== 2'b00) begin
            fails++;
            $display("FAIL w1_drain: got %b expected 00", {s_idx_vld, s_busy});
        end
    endtask

    // Reference: each instance holds a queue of indices still to emit, in emission order.
    task automatic test_random();
        int ql[$];
        int qm[$];
        bit rl, rm;
        tick();
        flush = 1'b1; vec_vld = 1'b0;
        tick();
        for (int c = 0; c < 600; c++) begin
            flush   = ($urandom_range(0, 19) == 0);
            vec_vld = $urandom_range(0, 1) == 1;
            vec     = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            idx_rdy = ($urandom_range(0, 9) < 7);
            rl = !flush && (ql.size() == 0 || (ql.size() == 1 && idx_rdy));
            rm = !flush && (qm.size() == 0 || (qm.size() == 1 && idx_rdy));
            @(negedge clk);
            tests++;
            if ({l_idx_vld, l_busy, l_vec_rdy} !== {ql.size() > 0, ql.size() > 0, rl}) begin
                fails++;
                $display("FAIL rand_lsb_ctrl cyc%0d: got vld/busy/rdy %b expected %b", c,
                         {l_idx_vld, l_busy, l_vec_rdy}, {ql.size() > 0, ql.size() > 0, rl});
            end
            tests++;
            if ({m_idx_vld, m_busy, m_vec_rdy} !== {qm.size() > 0, qm.size() > 0, rm}) begin
                fails++;
                $display("FAIL rand_msb_ctrl cyc%0d: got vld/busy/rdy %b expected %b", c,
                         {m_idx_vld, m_busy, m_vec_rdy}, {qm.size() > 0, qm.size() > 0, rm});
            end
            if (ql.size() > 0) begin
                tests++;
                if ({l_idx, l_idx_last} !== {3'(ql[0]), ql.size() == 1}) begin
                    fails++;
                    $display("FAIL rand_lsb_idx cyc%0d: got idx/last %0d/%b expected %0d/%b",
                             c, l_idx, l_idx_last, ql[0], ql.size() == 1);
                end
            end
            if (qm.size() > 0) begin
                tests++;
                if ({m_idx, m_idx_last} !== {3'(qm[0]), qm.size() == 1}) begin
                    fails++;
                    $display("FAIL rand_msb_idx cyc%0d: got idx/last %0d/%b expected %0d/%b",
                             c, m_idx, m_idx_last, qm[0], qm.size() == 1);
                end
            end
            if (flush) begin
                ql.delete();
                qm.delete();
            end else begin
                if (ql.size() > 0 && idx_rdy) void'(ql.pop_front());
                if (qm.size() > 0 && idx_rdy) void'(qm.pop_front());
                if (vec_vld && rl) begin
                    ql.delete();
                    for (int b = 0; b < 8; b++) if (vec[b]) ql.push_back(b);
                end
                if (vec_vld && rm) begin
                    qm.delete();
                    for (int b = 0; b < 8; b++) if (vec[b]) qm.push_front(b);
                end
            end
            tick();
        end
        flush = 1'b0; vec_vld = 1'b0;
    endtask

    initial begin
        test_reset();
        test_lsb_basic();
        test_msb_stall();
        test_back_to_back();
        test_zero_flush();
        test_w1();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
